// File: rtl/mem_rf_multiport_if.sv
// Bus bundle for the multi-read-port register file: one byte-masked write port,
// NRD read ports with packed addresses/data, plus the init-sweep busy flag.
interface mem_rf_multiport_if #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 256,
    parameter int NRD   = 2
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic                   we;
    logic [AW-1:0]          waddr;
    logic [WIDTH/8-1:0]     wbe;
    logic [WIDTH-1:0]       din;
    logic [NRD-1:0]         re;
    logic [NRD*AW-1:0]      raddr;
    logic [NRD*WIDTH-1:0]   q;
    logic                   busy;

    modport master (
        output we, waddr, wbe, din, re, raddr,
        input  q, busy
    );

    modport slave (
        input  we, waddr, wbe, din, re, raddr,
        output q, busy
    );
endinterface

// File: rtl/mem_rf_multiport.sv
// Multi-read-port register file with byte-masked writes, optional write-through
// on same-address collisions and an optional zeroing sweep after reset.
module mem_rf_multiport #(
    parameter int WIDTH     = 64,
    parameter int DEPTH     = 256,
    parameter int NRD       = 2,
    parameter int BYPASS    = 0,
    parameter int INIT_ZERO = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mem_rf_multiport_if.slave    bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int NB = WIDTH / 8;
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
    localparam logic [AW:0]   DEPTH_W   = (AW + 1)'(DEPTH);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_INIT = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic                 r_boot;
    logic [AW-1:0]        r_sweep;
    logic [AW-1:0]        w_sweep_nxt;
    logic [WIDTH-1:0]     r_mem [DEPTH];
    logic [NRD*WIDTH-1:0] r_q;

    logic                 w_run;
    logic                 w_waddr_ok;
    logic                 w_wr_en;
    logic [AW-1:0]        w_wr_addr;
    logic [NB-1:0]        w_wr_be;
    logic [WIDTH-1:0]     w_wr_data;
    logic [AW-1:0]        w_rd_addr [NRD];
    logic [WIDTH-1:0]     w_rd_word [NRD];

    function automatic logic [WIDTH-1:0] merge_bytes(
        input logic [WIDTH-1:0] old_word,
        input logic [WIDTH-1:0] new_word,
        input logic [NB-1:0]    be
    );
        logic [WIDTH-1:0] res;
        res = old_word;
        for (int b = 0; b < NB; b++) begin
            if (be[b]) begin
                res[8*b +: 8] = new_word[8*b +: 8];
            end
        end
        return res;
    endfunction

    // r_boot marks the first cycle after reset release; the FSM leaves it on that edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_RUN;
            r_boot  <= 1'b1;
            r_sweep <= {AW{1'b0}};
        end else begin
            r_state <= w_state_nxt;
            r_boot  <= 1'b0;
            r_sweep <= w_sweep_nxt;
        end
    end

    // Next-state and sweep counter
    always_comb begin
        w_state_nxt = r_state;
        w_sweep_nxt = r_sweep;
        if (r_boot) begin
            w_state_nxt = (INIT_ZERO != 0) ? ST_INIT : ST_RUN;
            w_sweep_nxt = {AW{1'b0}};
        end else begin
            case (r_state)
                ST_INIT: begin
                    if (r_sweep == LAST_ADDR) begin
                        w_state_nxt = ST_RUN;
                        w_sweep_nxt = {AW{1'b0}};
                    end else begin
                        w_sweep_nxt = r_sweep + AW'(1);
                    end
                end
                ST_RUN:  w_state_nxt = ST_RUN;
                default: w_state_nxt = ST_RUN;
            endcase
        end
    end

    // Write-port mux: the sweep owns the array while initialising
    always_comb begin
        w_run      = !r_boot && (r_state == ST_RUN);
        w_waddr_ok = ({1'b0, bus.waddr} < DEPTH_W);
        if (r_state == ST_INIT) begin
            w_wr_en   = 1'b1;
            w_wr_addr = r_sweep;
            w_wr_be   = {NB{1'b1}};
            w_wr_data = {WIDTH{1'b0}};
        end else begin
            w_wr_en   = w_run && bus.we && w_waddr_ok;
            w_wr_addr = bus.waddr;
            w_wr_be   = bus.wbe;
            w_wr_data = bus.din;
        end
    end

    // Byte-masked array write; the array itself is never reset
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            for (int b = 0; b < NB; b++) begin
                if (w_wr_be[b]) begin
                    r_mem[w_wr_addr][8*b +: 8] <= w_wr_data[8*b +: 8];
                end
            end
        end
    end

    // Per-port read word: out-of-range reads give zero, collisions may forward din
    always_comb begin
        for (int k = 0; k < NRD; k++) begin
            w_rd_addr[k] = bus.raddr[k*AW +: AW];
            w_rd_word[k] = {WIDTH{1'b0}};
            if ({1'b0, w_rd_addr[k]} < DEPTH_W) begin
                if ((BYPASS != 0) && w_run && w_wr_en && (w_wr_addr == w_rd_addr[k])) begin
                    w_rd_word[k] = merge_bytes(r_mem[w_rd_addr[k]], bus.din, bus.wbe);
                end else begin
                    w_rd_word[k] = r_mem[w_rd_addr[k]];
                end
            end else begin
                w_rd_word[k] = {WIDTH{1'b0}};
            end
        end
    end

    // Registered read data: forced to zero while sweeping, held when a port is idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= {(NRD*WIDTH){1'b0}};
        end else begin
            for (int k = 0; k < NRD; k++) begin
                if (r_state == ST_INIT) begin
                    r_q[k*WIDTH +: WIDTH] <= {WIDTH{1'b0}};
                end else if (w_run && bus.re[k]) begin
                    r_q[k*WIDTH +: WIDTH] <= w_rd_word[k];
                end
            end
        end
    end

    assign bus.q    = r_q;
    assign bus.busy = (r_state == ST_INIT);

endmodule

// File: tb/tb_mem_rf_multiport.sv
// Drives two register files (256 words read-before-write, 200 words write-through)
// with identical stimulus and compares both against an array-based reference model.
module tb_mem_rf_multiport;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic        t_we;
    logic [7:0]  t_waddr;
    logic [7:0]  t_wbe;
    logic [63:0] t_din;
    logic [1:0]  t_re;
    logic [7:0]  t_ra0;
    logic [7:0]  t_ra1;

    mem_rf_multiport_if #(.WIDTH(64), .DEPTH(256), .NRD(2)) if0 ();
    mem_rf_multiport_if #(.WIDTH(64), .DEPTH(200), .NRD(2)) if1 ();

    assign if0.we = t_we;   assign if1.we = t_we;
    assign if0.waddr = t_waddr; assign if1.waddr = t_waddr;
    assign if0.wbe = t_wbe; assign if1.wbe = t_wbe;
    assign if0.din = t_din; assign if1.din = t_din;
    assign if0.re = t_re;   assign if1.re = t_re;
    assign if0.raddr = {t_ra1, t_ra0};
    assign if1.raddr = {t_ra1, t_ra0};

    mem_rf_multiport #(.WIDTH(64), .DEPTH(256), .NRD(2), .BYPASS(0), .INIT_ZERO(1)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(if0));
    mem_rf_multiport #(.WIDTH(64), .DEPTH(200), .NRD(2), .BYPASS(1), .INIT_ZERO(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(if1));

    // Reference model: one word array per instance, expected q per instance/port
    logic [63:0] m [2][256];
    logic [63:0] e [2][2];
    int n_cmp  = 0;
    int n_fail = 0;
    int busy_cnt [2];

    function automatic int dep(input int i);
        return (i == 0) ? 256 : 200;
    endfunction

    function automatic logic [63:0] apply_be(input logic [63:0] old_w, input logic [63:0] new_w,
                                             input logic [7:0] be);
        logic [63:0] r;
        r = old_w;
        for (int b = 0; b < 8; b++) if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
        return r;
    endfunction

    function automatic logic [7:0] rand_addr();
        logic [7:0] a;
        case ($urandom_range(0, 3))
            0:       a = 8'($urandom_range(0, 7));
            1:       a = 8'($urandom_range(196, 203));
            default: a = 8'($urandom_range(0, 255));
        endcase
        return a;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string step, input logic b0, input logic b1);
        check($sformatf("%s_d0_q0", step), if0.q[63:0],   e[0][0]);
        check($sformatf("%s_d0_q1", step), if0.q[127:64], e[0][1]);
        check($sformatf("%s_d1_q0", step), if1.q[63:0],   e[1][0]);
        check($sformatf("%s_d1_q1", step), if1.q[127:64], e[1][1]);
        check($sformatf("%s_d0_busy", step), 64'(if0.busy), 64'(b0));
        check($sformatf("%s_d1_busy", step), 64'(if1.busy), 64'(b1));
    endtask

    task automatic model_step();
        int a;
        logic [63:0] w;
        for (int i = 0; i < 2; i++) begin
            for (int k = 0; k < 2; k++) begin
                if (t_re[k]) begin
                    a = (k == 0) ? int'(t_ra0) : int'(t_ra1);
                    if (a >= dep(i)) begin
                        e[i][k] = 64'd0;
                    end else begin
                        w = m[i][a];
                        if (i == 1 && t_we && int'(t_waddr) == a) w = apply_be(w, t_din, t_wbe);
                        e[i][k] = w;
                    end
                end
            end
            if (t_we && int'(t_waddr) < dep(i)) m[i][t_waddr] = apply_be(m[i][t_waddr], t_din, t_wbe);
        end
    endtask

    task automatic cycle(input string step);
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_outputs(step, 1'b0, 1'b0);
    endtask

    task automatic idle();
        t_we = 1'b0; t_re = 2'b00; t_wbe = 8'h00;
    endtask

    task automatic drive_random();
        t_we = 1'($urandom_range(0, 1));
        t_waddr = rand_addr();
        t_wbe = 8'($urandom);
        t_din = {$urandom, $urandom};
        t_re = 2'($urandom_range(0, 3));
        t_ra0 = rand_addr();
        t_ra1 = rand_addr();
    endtask

    // Called at a negedge: asserts reset, checks async clear, releases and tracks the sweep
    task automatic reset_and_sweep(input string step);
        rst_n = 1'b0;
        idle();
        #1;
        for (int i = 0; i < 2; i++) for (int k = 0; k < 2; k++) e[i][k] = 64'd0;
        check_outputs({step, "_rst"}, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            busy_cnt[i] = 0;
            for (int a = 0; a < 256; a++) m[i][a] = 64'd0;
        end
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (if0.busy === 1'b1) busy_cnt[0]++;
            if (if1.busy === 1'b1) busy_cnt[1]++;
            check_outputs($sformatf("%s_sweep%0d", step, c), 1'(c < 256), 1'(c < 200));
            if (c < 199) begin
                drive_random();
                t_we = 1'b1;
                t_re = 2'b11;
            end else begin
                idle();
            end
        end
        check({step, "_busylen0"}, 64'(busy_cnt[0]), 64'd256);
        check({step, "_busylen1"}, 64'(busy_cnt[1]), 64'd200);
    endtask

    task automatic read_all(input string step);
        for (int a = 0; a < 256; a += 2) begin
            t_we = 1'b0; t_re = 2'b11;
            t_ra0 = 8'(a); t_ra1 = 8'(a + 1);
            cycle(step);
        end
    endtask

    initial begin
        idle();
        t_waddr = 8'd0; t_din = 64'd0; t_ra0 = 8'd0; t_ra1 = 8'd0;
        @(negedge clk);
        reset_and_sweep("por");
        read_all("zero0");

        // Partial byte write merges into the existing word
        t_we = 1'b1; t_waddr = 8'd5; t_wbe = 8'hFF; t_din = 64'h1122334455667788; t_re = 2'b00;
        cycle("w5a");
        t_wbe = 8'h0F; t_din = 64'hAAAAAAAAAAAAAAAA;
        cycle("w5b");
        t_we = 1'b0; t_re = 2'b01; t_ra0 = 8'd5;
        cycle("r5");
        check("bytemask_d0", if0.q[63:0], 64'h11223344AAAAAAAA);
        check("bytemask_d1", if1.q[63:0], 64'h11223344AAAAAAAA);

        // Same-address collision: old word vs write-through
        t_we = 1'b1; t_waddr = 8'd9; t_wbe = 8'hFF; t_din = 64'h0123456789ABCDEF; t_re = 2'b00;
        cycle("w9x");
        t_din = 64'hFEDCBA9876543210; t_re = 2'b01; t_ra0 = 8'd9;
        cycle("w9y");
        check("collide_d0", if0.q[63:0], 64'h0123456789ABCDEF);
        check("collide_d1", if1.q[63:0], 64'hFEDCBA9876543210);

        // Two ports in one cycle, then port 0 holds
        t_we = 1'b1; t_waddr = 8'd3; t_wbe = 8'hFF; t_din = 64'h3333_0000_3333_0003; t_re = 2'b00;
        cycle("w3");
        t_waddr = 8'd200; t_din = 64'hC8C8_0000_C8C8_00C8;
        cycle("w200");
        t_we = 1'b0; t_re = 2'b11; t_ra0 = 8'd3; t_ra1 = 8'd200;
        cycle("r3_200");
        check("dual_d0_p0", if0.q[63:0],   64'h3333_0000_3333_0003);
        check("dual_d0_p1", if0.q[127:64], 64'hC8C8_0000_C8C8_00C8);
        check("dual_d1_p1", if1.q[127:64], 64'd0);
        t_re = 2'b10; t_ra0 = 8'd200; t_ra1 = 8'd3;
        cycle("hold0");
        check("hold_d0_p0", if0.q[63:0], 64'h3333_0000_3333_0003);
        t_re = 2'b11; t_ra0 = 8'd3; t_ra1 = 8'd3;
        cycle("same_addr");

        // Out-of-range write/read on the 200-word instance, last valid word
        t_we = 1'b1; t_waddr = 8'd250; t_wbe = 8'hFF; t_din = 64'h2502_5025_0250_2502; t_re = 2'b00;
        cycle("w250");
        t_we = 1'b0; t_re = 2'b01; t_ra0 = 8'd250;
        cycle("r250");
        check("oob_d1", if1.q[63:0], 64'd0);
        check("oob_d0", if0.q[63:0], 64'h2502_5025_0250_2502);
        t_we = 1'b1; t_waddr = 8'd199; t_din = 64'h1990_1990_1990_1990; t_re = 2'b00;
        cycle("w199");
        t_we = 1'b0; t_re = 2'b01; t_ra0 = 8'd199;
        cycle("r199");
        check("last_d1", if1.q[63:0], 64'h1990_1990_1990_1990);

        // All-zero byte enables leave the word untouched
        t_we = 1'b1; t_waddr = 8'd3; t_wbe = 8'h00; t_din = 64'hDEAD_BEEF_DEAD_BEEF; t_re = 2'b00;
        cycle("wbe0");
        t_we = 1'b0; t_re = 2'b01; t_ra0 = 8'd3;
        cycle("r_wbe0");
        check("wbe0_d0", if0.q[63:0], 64'h3333_0000_3333_0003);

        for (int n = 0; n < 2000; n++) begin
            drive_random();
            cycle("rand");
        end

        // Reset while running re-clears the array
        @(negedge clk);
        reset_and_sweep("run_rst");
        read_all("zero1");

        // Reset in the middle of the sweep (address 100) restarts it from scratch
        idle();
        t_we = 1'b1; t_waddr = 8'd7; t_wbe = 8'hFF; t_din = 64'h7777_7777_7777_7777;
        cycle("pre_abort");
        idle();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (101) @(negedge clk);
        check("mid_sweep_busy0", 64'(if0.busy), 64'd1);
        reset_and_sweep("abort");
        read_all("zero2");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_rf_multiport.md
MEM_RF_MULTIPORT -- requirements
Module: mem_rf_multiport

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  WIDTH  64  data word width in bits; SHALL be a multiple of 8
  DEPTH  256  number of words; need not be a power of 2
  NRD  2  number of independent read ports, 1..8
  BYPASS  0  0 = read-before-write on same-address collision; 1 = write-through
  INIT_ZERO  1  1 = sweep array to zero after reset; 0 = no sweep
REQ-002 AW SHALL be derived as max(1, ceil(log2(DEPTH))); it SHALL NOT be a user parameter.
REQ-003 Ports SHALL be, one per line: name  direction  width  meaning.
  clk  in  1  single clock, rising edge
  rst_n  in  1  asynchronous, active-low reset
  we  in  1  write enable
  waddr  in  AW  write address
  wbe  in  WIDTH/8  byte enables; bit i qualifies din[8i+7:8i]
  din  in  WIDTH  write data
  re  in  NRD  per-port read enable
  raddr  in  NRD*AW  read addresses; port k at [k*AW +: AW]
  q  out  NRD*WIDTH  registered read data; port k at [k*WIDTH +: WIDTH]
  busy  out  1  high while the init sweep runs

Function
REQ-010 Control SHALL use a two-state FSM: INIT, RUN.
REQ-011 On reset release, the FSM SHALL enter INIT if INIT_ZERO=1, else RUN.
REQ-012 In INIT, a sweep counter SHALL write all-zero to address 0, 1, ..., DEPTH-1, one word per cycle.
REQ-013 After address DEPTH-1 is written, the FSM SHALL move to RUN on the next edge; INIT SHALL last exactly DEPTH cycles.
REQ-014 busy SHALL be 1 exactly while in INIT.
REQ-015 In INIT, we and re SHALL be ignored and q SHALL hold 0.
REQ-016 In RUN, with we=1 and waddr<DEPTH, only the bytes with wbe[i]=1 SHALL be updated at the clock edge.
REQ-017 A write with wbe all-zero SHALL leave the array unchanged.
REQ-018 In RUN, with re[k]=1, q port k SHALL present word raddr port k one cycle later (latency 1).
REQ-019 With re[k]=0, q port k SHALL hold its previous value.
REQ-020 A write SHALL be visible to any read issued in a later cycle.
REQ-021 Same-cycle collision (re[k]=1, we=1, raddr k == waddr), BYPASS=0: q port k SHALL return the pre-write word.
REQ-022 Same-cycle collision, BYPASS=1: q port k SHALL return the pre-write word with the enabled bytes replaced by din.
REQ-023 Writes with waddr>=DEPTH SHALL be dropped.
REQ-024 Reads with raddr>=DEPTH SHALL return 0.
REQ-025 All read ports SHALL operate independently; identical addresses on several ports SHALL return identical data.

Reset
REQ-030 With rst_n=0, q SHALL be 0 and busy SHALL be 0, asynchronously.
REQ-031 With rst_n=0, the FSM SHALL be held and the sweep counter SHALL be 0.
REQ-032 Array contents SHALL NOT be reset by rst_n; they are cleared only by the INIT sweep.
REQ-033 A reset asserted during INIT SHALL restart the sweep from address 0 on release.
REQ-034 A reset asserted during RUN with INIT_ZERO=1 SHALL re-clear the whole array.

Verification
REQ-040 INIT_ZERO=1, DEPTH=256: release rst_n -> busy=1 for exactly 256 cycles; afterwards a read of any address returns 0.
REQ-041 WIDTH=64: write 0x1122334455667788 to address 5 with wbe=0xFF, then write 0xAAAA... to address 5 with wbe=0x0F, then read address 5 -> q=0x11223344AAAAAAAA.
REQ-042 Write address 9 = X, then next cycle write Y to 9 while port 0 reads 9 -> BYPASS=0 returns X, BYPASS=1 returns Y.
REQ-043 NRD=2: ports 0 and 1 read addresses 3 and 200 in the same cycle -> both words correct after 1 cycle; drop re[0] -> port 0 q holds.
REQ-044 DEPTH=200: write to address 250, then read address 250 -> write dropped, q=0; address 199 read/write works normally.
REQ-045 Assert rst_n=0 at sweep address 100 -> q=0 and busy=0 immediately; on release busy=1 for the full 256 cycles again.
